seq_pattern_tx: RTL and testbench

//  Serial bit-pattern transmitter: the source for the serial sequence detectors.

---
 rtl/seq_tx_pkg.sv | 16 +
 rtl/seq_tx_piso.sv | 67 ++++++
 rtl/seq_pattern_tx.sv | 138 +++++++++++++
 tb/tb_seq_pattern_tx.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_tx_pkg.sv
// Shared types and default sizing for the serial pattern transmitter.
// State encodings are fixed so they stay stable in waveforms and debug probes.
package seq_tx_pkg;

   localparam int DEF_PAT_W = 8;
   localparam int DEF_REP_W = 4;
   localparam int DEF_GAP_W = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2,
      DONE  = 2'd3
   } tx_state_e;

endpackage

// File: rtl/seq_tx_piso.sv
// Loadable parallel-in/serial-out register, MSB-first, with a per-repetition bit counter.
// Holds a copy of the request so the pattern can be replayed for each repetition.
module seq_tx_piso
   import seq_tx_pkg::*;
#(
   parameter int PAT_W = DEF_PAT_W,
   parameter int LEN_W = $clog2(PAT_W + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             reload,
   input  logic             shift,
   input  logic [PAT_W-1:0] pat_i,
   input  logic [LEN_W-1:0] len_i,
   output logic             msb_o,
   output logic             last_bit_o
);

   logic [PAT_W-1:0] sr_q, sr_d;
   logic [PAT_W-1:0] pat_q, pat_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic [LEN_W-1:0] len_q, len_d;

   // Left-align the used bits so bit len-1 lands in the MSB; unused upper bits fall off.
   function automatic logic [PAT_W-1:0] align(input logic [PAT_W-1:0] p,
                                              input logic [LEN_W-1:0] l);
      return p << (PAT_W - int'(l));
   endfunction

   always_comb begin
      sr_d  = sr_q;
      pat_d = pat_q;
      cnt_d = cnt_q;
      len_d = len_q;
      if (load) begin
         pat_d = pat_i;
         len_d = len_i;
         sr_d  = align(pat_i, len_i);
         cnt_d = len_i;
      end else if (reload) begin
         sr_d  = align(pat_q, len_q);
         cnt_d = len_q;
      end else if (shift) begin
         sr_d  = {sr_q[PAT_W-2:0], 1'b0};
         cnt_d = cnt_q - LEN_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sr_q  <= '0;
         pat_q <= '0;
         cnt_q <= '0;
         len_q <= '0;
      end else begin
         sr_q  <= sr_d;
         pat_q <= pat_d;
         cnt_q <= cnt_d;
         len_q <= len_d;
      end
   end

   assign msb_o      = sr_q[PAT_W-1];
   assign last_bit_o = (cnt_q == LEN_W'(1));

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial bit-pattern transmitter: latches a request, then shifts the pattern out
// MSB-first for rep+1 repetitions with optional idle gaps between them.
module seq_pattern_tx
   import seq_tx_pkg::*;
#(
   parameter int PAT_W = DEF_PAT_W,
   parameter int LEN_W = $clog2(PAT_W + 1),
   parameter int REP_W = DEF_REP_W,
   parameter int GAP_W = DEF_GAP_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [PAT_W-1:0] pat_i,
   input  logic [LEN_W-1:0] len_i,
   input  logic [REP_W-1:0] rep_i,
   input  logic [GAP_W-1:0] gap_i,
   input  logic             abort,
   output logic             dout,
   output logic             dout_valid,
   output logic             busy,
   output logic             done,
   output logic             aborted
);

   tx_state_e        state_q, state_d;
   logic [REP_W-1:0] rep_q, rep_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
   logic             aborted_q, aborted_d;

   logic             piso_load, piso_reload, piso_shift;
   logic             piso_msb, last_bit;
   logic [LEN_W-1:0] len_clamp;

   assign len_clamp = (len_i > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : len_i;

   seq_tx_piso #(
      .PAT_W (PAT_W),
      .LEN_W (LEN_W)
   ) u_piso (
      .clk        (clk),
      .reset      (reset),
      .load       (piso_load),
      .reload     (piso_reload),
      .shift      (piso_shift),
      .pat_i      (pat_i),
      .len_i      (len_clamp),
      .msb_o      (piso_msb),
      .last_bit_o (last_bit)
   );

   always_comb begin
      state_d     = state_q;
      rep_d       = rep_q;
      gap_d       = gap_q;
      gap_cnt_d   = gap_cnt_q;
      aborted_d   = aborted_q;
      piso_load   = 1'b0;
      piso_reload = 1'b0;
      piso_shift  = 1'b0;
      unique case (state_q)
         IDLE: begin
            aborted_d = 1'b0;
            if (req_valid) begin
               rep_d     = rep_i;
               gap_d     = gap_i;
               piso_load = 1'b1;
               state_d   = (len_clamp == '0) ? DONE : SHIFT;
            end
         end
         SHIFT: begin
            // Abort wins over the end-of-repetition decision on the same cycle.
            if (abort) begin
               state_d   = DONE;
               aborted_d = 1'b1;
            end else if (last_bit) begin
               if (rep_q == '0) begin
                  state_d = DONE;
               end else begin
                  rep_d = rep_q - REP_W'(1);
                  if (gap_q == '0) begin
                     piso_reload = 1'b1;
                  end else begin
                     state_d   = GAP;
                     gap_cnt_d = GAP_W'(1);
                  end
               end
            end else begin
               piso_shift = 1'b1;
            end
         end
         GAP: begin
            if (abort) begin
               state_d   = DONE;
               aborted_d = 1'b1;
            end else if (gap_cnt_q == gap_q) begin
               state_d     = SHIFT;
               piso_reload = 1'b1;
            end else begin
               gap_cnt_d = gap_cnt_q + GAP_W'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         rep_q     <= '0;
         gap_q     <= '0;
         gap_cnt_q <= '0;
         aborted_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         rep_q     <= rep_d;
         gap_q     <= gap_d;
         gap_cnt_q <= gap_cnt_d;
         aborted_q <= aborted_d;
      end
   end

   // Outputs decode from state/registers only, forced low while reset is asserted.
   assign req_ready  = !reset && (state_q == IDLE);
   assign dout_valid = !reset && (state_q == SHIFT);
   assign dout       = dout_valid && piso_msb;
   assign busy       = !reset && ((state_q == SHIFT) || (state_q == GAP));
   assign done       = !reset && (state_q == DONE);
   assign aborted    = done && aborted_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Randomized and directed bench for seq_pattern_tx against a queue-based serial model.
module tb_seq_pattern_tx;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic [7:0] pat_i = '0;
   logic [3:0] len_i = '0;
   logic [3:0] rep_i = '0;
   logic [3:0] gap_i = '0;
   logic       abort = 1'b0;
   logic       dout, dout_valid, busy, done, aborted;

   int n_vec = 0;
   int n_err = 0;
   int exp_q[$];   // 0/1 = data bit cycle, 2 = idle gap cycle

   always #5 clk = ~clk;

   seq_pattern_tx dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .pat_i      (pat_i),
      .len_i      (len_i),
      .rep_i      (rep_i),
      .gap_i      (gap_i),
      .abort      (abort),
      .dout       (dout),
      .dout_valid (dout_valid),
      .busy       (busy),
      .done       (done),
      .aborted    (aborted)
   );

   // Expected cycle-by-cycle stream between accept and DONE.
   function automatic void build(input logic [7:0] pat, input int len, input int rep, input int gap);
      int l;
      exp_q.delete();
      l = (len > 8) ? 8 : len;
      if (l == 0) return;
      for (int r = 0; r <= rep; r++) begin
         for (int b = l - 1; b >= 0; b--) exp_q.push_back(int'(pat[b]));
         if (r < rep) for (int g = 0; g < gap; g++) exp_q.push_back(2);
      end
   endfunction

   // One transfer: abort_at is a stream index to abort on (out of range = none);
   // hold keeps req_valid asserted after the accept.
   task automatic test_transfer(input string name, input logic [7:0] pat, input int len,
                                input int rep, input int gap, input int abort_at, input bit hold);
      int  n;
      bit  ab;
      logic ev, ed;
      build(pat, len, rep, gap);
      ab = (abort_at >= 0) && (abort_at < exp_q.size());
      n  = ab ? abort_at + 1 : exp_q.size();
      n_vec++;
      if (req_ready !== 1'b1) begin
         n_err++;
         $display("FAIL %s ready_before_req: got %b want 1", name, req_ready);
      end
      pat_i = pat; len_i = 4'(len); rep_i = 4'(rep); gap_i = 4'(gap);
      req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if (!hold) req_valid = 1'b0;
      for (int i = 0; i < n; i++) begin
         ev = (exp_q[i] != 2);
         ed = (exp_q[i] == 1);
         n_vec++;
         if ({dout_valid, dout, busy, done, req_ready} !== {ev, ed, 1'b1, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL %s cycle%0d {valid,dout,busy,done,ready}: got %b%b%b%b%b want %b%b100",
                     name, i, dout_valid, dout, busy, done, req_ready, ev, ed);
         end
         if (i == abort_at) abort = 1'b1;
         @(negedge clk);
      end
      abort = 1'b0;
      n_vec++;
      if ({done, aborted, dout_valid, dout, busy, req_ready} !== {1'b1, ab, 4'b0000}) begin
         n_err++;
         $display("FAIL %s done_cycle {done,aborted,valid,dout,busy,ready}: got %b%b%b%b%b%b want 1%b0000",
                  name, done, aborted, dout_valid, dout, busy, req_ready, ab);
      end
      @(negedge clk);
      n_vec++;
      if ({done, aborted, busy, dout_valid, req_ready} !== 5'b00001) begin
         n_err++;
         $display("FAIL %s idle_after_done {done,aborted,busy,valid,ready}: got %b%b%b%b%b want 00001",
                  name, done, aborted, busy, dout_valid, req_ready);
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_vec++;
      if ({req_ready, dout, dout_valid, busy, done, aborted} !== 6'b0) begin
         n_err++;
         $display("FAIL reset_held outputs: got %b%b%b%b%b%b want 000000",
                  req_ready, dout, dout_valid, busy, done, aborted);
      end
      reset = 1'b0;
      @(negedge clk);
      n_vec++;
      if ({req_ready, dout, dout_valid, busy, done, aborted} !== 6'b100000) begin
         n_err++;
         $display("FAIL reset_release outputs: got %b%b%b%b%b%b want 100000",
                  req_ready, dout, dout_valid, busy, done, aborted);
      end
   endtask

   task automatic test_reset_mid();
      pat_i = 8'hA5; len_i = 4'd8; rep_i = 4'd0; gap_i = 4'd0;
      req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      n_vec++;
      if ({dout_valid, dout, busy} !== 3'b111) begin
         n_err++;
         $display("FAIL rst_mid first_bit {valid,dout,busy}: got %b%b%b want 111", dout_valid, dout, busy);
      end
      @(negedge clk);
      reset = 1'b1;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         n_vec++;
         if ({req_ready, dout, dout_valid, busy, done, aborted} !== 6'b0) begin
            n_err++;
            $display("FAIL rst_mid during_reset%0d outputs: got %b%b%b%b%b%b want 000000",
                     c, req_ready, dout, dout_valid, busy, done, aborted);
         end
      end
      reset = 1'b0;
      req_valid = 1'b0;
      #1;
      n_vec++;
      if ({req_ready, busy, dout_valid, done} !== 4'b1000) begin
         n_err++;
         $display("FAIL rst_mid after_release {ready,busy,valid,done}: got %b%b%b%b want 1000",
                  req_ready, busy, dout_valid, done);
      end
      @(negedge clk);
      n_vec++;
      if ({req_ready, busy, done} !== 3'b100) begin
         n_err++;
         $display("FAIL rst_mid idle {ready,busy,done}: got %b%b%b want 100", req_ready, busy, done);
      end
   endtask

   task automatic test_abort_idle();
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      n_vec++;
      if ({req_ready, busy, done, aborted} !== 4'b1000) begin
         n_err++;
         $display("FAIL abort_idle {ready,busy,done,aborted}: got %b%b%b%b want 1000",
                  req_ready, busy, done, aborted);
      end
   endtask

   task automatic test_back_to_back();
      test_transfer("b2b_first", 8'hA5, 8, 0, 0, -1, 1'b1);
      test_transfer("b2b_second", 8'hA5, 8, 0, 0, -1, 1'b0);
   endtask

   task automatic test_random();
      for (int t = 0; t < 40; t++) begin
         logic [7:0] p;
         int l, r, g, a;
         p = 8'($urandom);
         l = $urandom_range(0, 11);
         r = $urandom_range(0, 3);
         g = $urandom_range(0, 3);
         a = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 30) : -1;
         test_transfer($sformatf("rand%0d", t), p, l, r, g, a, 1'b0);
      end
   endtask

   initial begin
      test_reset();
      test_transfer("t1_rep2_gap0", 8'h05, 3, 2, 0, -1, 1'b0);
      test_transfer("t2_rep1_gap2", 8'h05, 3, 1, 2, -1, 1'b0);
      test_transfer("t3_len0", 8'hFF, 0, 3, 2, -1, 1'b0);
      test_transfer("t4_abort_bit3", 8'hA5, 8, 0, 0, 2, 1'b0);
      test_transfer("abort_in_gap", 8'h0B, 4, 1, 3, 5, 1'b0);
      test_transfer("abort_last_bit", 8'h03, 2, 1, 0, 3, 1'b0);
      test_transfer("len_clamp", 8'hC3, 13, 0, 0, -1, 1'b0);
      test_transfer("max_gap", 8'h01, 1, 2, 15, -1, 1'b0);
      test_abort_idle();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
